key_event_uart_tx: RTL
======================

# key_event_uart_tx

Drains key events from the keyboard event FIFO and sends each one to the host as an asynchronous serial frame. The frame is a start bit, 8 data bits LSB first, an even parity bit and a stop bit. It sits on the read side of the event FIFO: the scanner writes events, and this block pulses the FIFO read strobe, samples the FIFO output and serialises the event. A FIFO output of all zeros means "empty", so the all-zero event code is reserved and never transmitted.

## Interface
Parameters:
- EVENT_WIDTH, 8, event word width; must match the FIFO.
- BAUD_DIV, 434, clk cycles per serial bit; minimum 2.
- POLL_DIV, 1024, clk cycles between polls of an empty FIFO; minimum 1.
- RD_PULSE, 2, clk cycles FifoRd is held high per read.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- TxEnable  in  1  allows new FIFO reads; a frame in progress always completes.
- FifoData  in  EVENT_WIDTH  FIFO output word.
- FifoRd  out  1  FIFO read strobe; the FIFO advances on its rising edge.
- Tx  out  1  serial line; idles high.
- TxBusy  out  1  high from the FifoRd assertion until the end of the stop bit, or until an empty result returns the block to IDLE.
- EventSent  out  1  one-clk pulse on the last cycle of the stop bit.

## Operation
- Reset values (immediate, asynchronous): Tx=1, FifoRd=0, TxBusy=0, EventSent=0, all counters 0, state IDLE.
- All outputs are registered.
- States: IDLE, RD_STROBE, RD_SETTLE, SAMPLE, START, DATA, PARITY, STOP, POLL_WAIT.
- IDLE:
  - TxEnable=1 -> RD_STROBE.
  - TxEnable=0 -> stay in IDLE; Tx=1.
- RD_STROBE: FifoRd=1 for RD_PULSE cycles -> RD_SETTLE.
- RD_SETTLE: FifoRd=0 for 2 cycles, giving FifoData time to settle -> SAMPLE.
- SAMPLE: one cycle; FifoData is captured into the shift register.
  - Captured word == 0 -> POLL_WAIT; the FIFO is empty and nothing is sent.
  - Otherwise -> START; parity = XOR of the data bits, so the 9 bits (data + parity) contain an even number of ones.
- START: Tx=0 for BAUD_DIV cycles.
- DATA: EVENT_WIDTH bits, LSB first, each BAUD_DIV cycles.
- PARITY: parity bit for BAUD_DIV cycles.
- STOP: Tx=1 for BAUD_DIV cycles; EventSent pulses on the final cycle. Then:
  - TxEnable=1 -> RD_STROBE; back-to-back frames, no idle gap.
  - TxEnable=0 -> IDLE.
- POLL_WAIT: waits POLL_DIV cycles with Tx=1 -> IDLE.
- TxEnable deasserted mid-frame: the frame finishes unchanged; no further read is issued.
- TxEnable deasserted during RD_STROBE or RD_SETTLE: the read completes and the captured event is transmitted, so no event is ever lost.
- rst asserted mid-frame: Tx goes high immediately. The frame is truncated and that event is lost. The FIFO is reset by the same rst.
- Counter widths: baud counter $clog2(BAUD_DIV), poll counter $clog2(POLL_DIV+1), bit index $clog2(EVENT_WIDTH+1). All counters count down and reload on state entry.

## Timing
- Read latency: FifoRd rises 1 clk after TxEnable is seen high in IDLE. Capture happens RD_PULSE+2 cycles after the FifoRd rise.
- Tx falls (start bit) 1 clk after SAMPLE.
- Frame length: (EVENT_WIDTH+3)*BAUD_DIV clk cycles; 11*BAUD_DIV at the default width.
- Frame-to-frame period with back-to-back events: (EVENT_WIDTH+3)*BAUD_DIV + RD_PULSE + 3 cycles.
- Empty poll period: RD_PULSE + 3 + POLL_DIV + 1 cycles.
- Bit edges are cycle-exact; no jitter or accumulated drift is permitted.

## Structure
- Package key_event_pkg holds:
  - state enum for the FSM;
  - FRAME_START=1'b0 and FRAME_STOP=1'b1;
  - EVENT_EMPTY = all-zeros constant;
  - a function computing even parity.
- Sub-module baud_counter: down-counter with load and a terminal-count output, parameterised by BAUD_DIV. Instantiated once and reused for bit timing. The poll timer stays inline.

## Test plan
Simulation uses BAUD_DIV=4, POLL_DIV=8, RD_PULSE=2.
- Reset, then TxEnable=1 with FIFO empty (FifoData=0) -> FifoRd pulses every 14 clk; Tx stays 1; EventSent never pulses.
- FIFO holds 8'hA5, TxEnable=1:
  - Tx sequence sampled every 4 clk: 0, 1,0,1,0,0,1,0,1, 0, 1 (parity 0, since 0xA5 has 4 ones);
  - frame is 44 clk long; EventSent is a single pulse.
- FIFO holds 8'h01, 8'h07, TxEnable=1:
  - two back-to-back frames with parity bits 1 and 1 (one and three ones respectively);
  - 49 clk between the two start-bit falling edges;
  - then empty polling resumes.
- TxEnable dropped during bit 3 of an 8'h3C frame -> the frame completes with correct parity 0; no FifoRd afterwards; TxBusy falls after the stop bit.
- rst pulsed during DATA -> Tx=1, FifoRd=0 and TxBusy=0 within the same cycle as the rst rise (asynchronous, no clk edge needed); after release, IDLE and Tx remains 1.
- Random events (1..255) against a bench UART receiver model -> every event received in order with correct parity; count of EventSent pulses equals the count of FIFO writes.

Source files
------------

// File: rtl/key_event_pkg.sv
// Shared types and helpers for the key event serial transmitter.
// Frame levels, empty-event marker and parity live here.
package key_event_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RD_STROBE,
        RD_SETTLE,
        SAMPLE,
        START,
        DATA,
        PARITY,
        STOP,
        POLL_WAIT
    } txState_t;

    localparam logic FRAME_START = 1'b0;
    localparam logic FRAME_STOP  = 1'b1;

    // Wide enough for any event width; slice to the word in use.
    localparam logic [63:0] EVENT_EMPTY = '0;

    function automatic logic evenParity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/key_event_uart_tx_baud.sv
// Bit-period down-counter with load and terminal count.
// Reloads to BAUD_DIV-1 and holds at zero until the next load.
module baud_counter #(
    parameter int BAUD_DIV = 434
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load,
    output logic [$clog2(BAUD_DIV)-1:0] count,
    output logic                        tc
);

    localparam int CW = $clog2(BAUD_DIV);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(BAUD_DIV - 1);
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/key_event_uart_tx.sv
// Reads key events from the event FIFO and sends each as an
// 8E1-style serial frame (start, data LSB first, even parity, stop).
import key_event_pkg::*;

module key_event_uart_tx #(
    parameter int EVENT_WIDTH = 8,
    parameter int BAUD_DIV    = 434,
    parameter int POLL_DIV    = 1024,
    parameter int RD_PULSE    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   TxEnable,
    input  logic [EVENT_WIDTH-1:0] FifoData,
    output logic                   FifoRd,
    output logic                   Tx,
    output logic                   TxBusy,
    output logic                   EventSent
);

    localparam int BW = $clog2(BAUD_DIV);
    localparam int PW = $clog2(POLL_DIV + 1);
    localparam int IW = $clog2(EVENT_WIDTH + 1);
    localparam int RW = $clog2(RD_PULSE + 2);

    txState_t               state;
    logic [EVENT_WIDTH-1:0] shiftReg;
    logic                   parityBit;
    logic [PW-1:0]          pollCnt;
    logic [IW-1:0]          bitIdx;
    logic [RW-1:0]          rdCnt;
    logic [BW-1:0]          baudCount;
    logic                   baudTc;
    logic                   baudLoad;
    logic                   inBit;
    logic                   isEmpty;

    assign inBit = (state == START) || (state == DATA) ||
                   (state == PARITY) || (state == STOP);

    // Reload on entry to START and at every bit boundary.
    assign baudLoad = (state == SAMPLE) || (inBit && baudTc);

    assign isEmpty = (FifoData == EVENT_EMPTY[EVENT_WIDTH-1:0]);

    baud_counter #(
        .BAUD_DIV(BAUD_DIV)
    ) uBaud (
        .clk  (clk),
        .rst  (rst),
        .load (baudLoad),
        .count(baudCount),
        .tc   (baudTc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            Tx        <= FRAME_STOP;
            FifoRd    <= 1'b0;
            TxBusy    <= 1'b0;
            EventSent <= 1'b0;
            shiftReg  <= '0;
            parityBit <= 1'b0;
            pollCnt   <= '0;
            bitIdx    <= '0;
            rdCnt     <= '0;
        end else begin
            EventSent <= 1'b0;
            unique case (state)
                IDLE: begin
                    Tx <= FRAME_STOP;
                    if (TxEnable) begin
                        state  <= RD_STROBE;
                        FifoRd <= 1'b1;
                        TxBusy <= 1'b1;
                        rdCnt  <= RW'(RD_PULSE - 1);
                    end
                end
                RD_STROBE: begin
                    if (rdCnt == '0) begin
                        state  <= RD_SETTLE;
                        FifoRd <= 1'b0;
                        rdCnt  <= RW'(1);
                    end else begin
                        rdCnt <= rdCnt - 1'b1;
                    end
                end
                RD_SETTLE: begin
                    if (rdCnt == '0) begin
                        state <= SAMPLE;
                    end else begin
                        rdCnt <= rdCnt - 1'b1;
                    end
                end
                SAMPLE: begin
                    shiftReg  <= FifoData;
                    parityBit <= evenParity(64'(FifoData));
                    if (isEmpty) begin
                        state   <= POLL_WAIT;
                        pollCnt <= PW'(POLL_DIV - 1);
                    end else begin
                        state <= START;
                        Tx    <= FRAME_START;
                    end
                end
                START: begin
                    if (baudTc) begin
                        state  <= DATA;
                        Tx     <= shiftReg[0];
                        bitIdx <= IW'(EVENT_WIDTH - 1);
                    end
                end
                DATA: begin
                    if (baudTc) begin
                        if (bitIdx == '0) begin
                            state <= PARITY;
                            Tx    <= parityBit;
                        end else begin
                            shiftReg <= shiftReg >> 1;
                            Tx       <= shiftReg[1];
                            bitIdx   <= bitIdx - 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (baudTc) begin
                        state <= STOP;
                        Tx    <= FRAME_STOP;
                    end
                end
                STOP: begin
                    // Registered, so raise it one cycle ahead of the last.
                    if (baudCount == BW'(1)) begin
                        EventSent <= 1'b1;
                    end
                    if (baudTc) begin
                        if (TxEnable) begin
                            state  <= RD_STROBE;
                            FifoRd <= 1'b1;
                            rdCnt  <= RW'(RD_PULSE - 1);
                        end else begin
                            state  <= IDLE;
                            TxBusy <= 1'b0;
                        end
                    end
                end
                POLL_WAIT: begin
                    if (pollCnt == '0) begin
                        state  <= IDLE;
                        TxBusy <= 1'b0;
                    end else begin
                        pollCnt <= pollCnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
